// File: rtl/game_pkg.sv
// Shared definitions for the game-flow controller: state encodings and pacing limits.
package game_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned MIN_GAP = 2;

  typedef enum logic [STATE_W-1:0] {
    StIdle  = 3'd0,
    StClear = 3'd1,
    StPlay  = 3'd2,
    StDrain = 3'd3,
    StOver  = 3'd4
  } game_state_e;

endpackage

// File: rtl/score_pulse_gen.sv
// Saturating pending-event counter plus a paced one-cycle pulse emitter.
module score_pulse_gen
  import game_pkg::*;
#(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned ADD_W = 3,
  parameter int unsigned GAP   = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [ADD_W-1:0] add_cnt,
  output logic             plus,
  output logic [CNT_W-1:0] pending,
  output logic             overflow_evt,
  output logic             idle
);

  localparam int unsigned GapEff = (GAP < MIN_GAP) ? MIN_GAP : GAP;
  localparam int unsigned GapW   = $clog2(GapEff);
  localparam int unsigned SumW   = CNT_W + ADD_W + 1;
  localparam logic [SumW-1:0] Max = {{(ADD_W + 1){1'b0}}, {CNT_W{1'b1}}};

  logic [CNT_W-1:0] pending_q;
  logic [GapW-1:0]  gap_q;
  logic             plus_q;
  logic             launch;
  logic [SumW-1:0]  sum;

  // The decrement is taken in the launch cycle, so pending drops as plus rises.
  always_comb begin
    launch = en && (pending_q != '0) && (gap_q == '0);
    sum    = SumW'(pending_q) + SumW'(add_cnt) - SumW'(launch);
  end

  assign overflow_evt = en && (sum > Max);

  always_ff @(posedge clk) begin
    if (clr) begin
      pending_q <= '0;
      gap_q     <= '0;
      plus_q    <= 1'b0;
    end else begin
      plus_q <= launch;
      if (en) begin
        pending_q <= (sum > Max) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
      end
      if (launch) begin
        gap_q <= GapW'(GapEff - 1);
      end else if (gap_q != '0) begin
        gap_q <= gap_q - 1'b1;
      end
    end
  end

  assign plus    = plus_q;
  assign pending = pending_q;
  assign idle    = (pending_q == '0) && !plus_q && (gap_q == '0);

endmodule

// File: rtl/score_event_sequencer.sv
// Game-flow FSM that arbitrates scoring requests into paced plus pulses for the score counter.
module score_event_sequencer
  import game_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP   = 2
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic               crash,
  input  logic [N_REQ-1:0]   req,
  output logic               plus,
  output logic               score_clr,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   pending,
  output logic               overflow,
  output logic               idle
);

  localparam int unsigned AddW = $clog2(N_REQ + 1);

  game_state_e     state_q;
  logic            score_clr_q;
  logic            overflow_q;
  logic [AddW-1:0] req_cnt;
  logic [AddW-1:0] add_cnt;
  logic            en;
  logic            flush;
  logic            overflow_evt;
  logic            gen_idle;

  always_comb begin
    req_cnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_cnt = req_cnt + AddW'(req[i]);
    end
  end

  // Requests only count while playing; DRAIN just empties the backlog.
  assign add_cnt = (state_q == StPlay) ? req_cnt : '0;
  assign en      = (state_q == StPlay) || (state_q == StDrain);
  assign flush   = clr || (state_q == StClear);

  score_pulse_gen #(
    .CNT_W(CNT_W),
    .ADD_W(AddW),
    .GAP  (GAP)
  ) u_pulse_gen (
    .clk         (clk),
    .clr         (flush),
    .en          (en),
    .add_cnt     (add_cnt),
    .plus        (plus),
    .pending     (pending),
    .overflow_evt(overflow_evt),
    .idle        (gen_idle)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= StIdle;
      score_clr_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      score_clr_q <= 1'b0;
      if (state_q == StClear) begin
        overflow_q <= 1'b0;
      end else if (overflow_evt) begin
        overflow_q <= 1'b1;
      end
      case (state_q)
        StIdle, StOver: begin
          if (start) begin
            state_q     <= StClear;
            score_clr_q <= 1'b1;
          end
        end
        StClear: state_q <= StPlay;
        StPlay:  if (crash) state_q <= StDrain;
        StDrain: if (gen_idle) state_q <= StOver;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign score_clr = score_clr_q;
  assign state     = state_q;
  assign overflow  = overflow_q;
  assign idle      = gen_idle;

endmodule
